ghost_arena_multi: RTL

Parametrised N-player successor to the two-ghost sprite/bullet layer. Per player it owns a bullet state machine, hit detection against every other live player, a lives counter and a hit-flash timer. It composites player boxes and bullets onto the incoming pixel stream. It sits in the video pipeline after the background core and before the VGA sync output, with debounced joystick and button signals already scaled to screen coordinates.

---
 rtl/ghost_arena_multi_if.sv | 35 +++
 rtl/ghost_arena_multi.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghost_arena_multi_if.sv
// ghost_arena_multi_if: pixel, player and game-state bundle
// between the video pipeline and the arena layer.
interface ghost_arena_multi_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int CD = 12,
  parameter int COORD_W = 11
);
  logic                         frame_tick;
  logic                         restart;
  logic [COORD_W-1:0]           x;
  logic [COORD_W-1:0]           y;
  logic [NUM_PLAYERS*COORD_W-1:0] pos_x;
  logic [NUM_PLAYERS*COORD_W-1:0] pos_y;
  logic [NUM_PLAYERS*2-1:0]     orientation;
  logic [NUM_PLAYERS-1:0]       fire;
  logic [NUM_PLAYERS*CD-1:0]    colour;
  logic [CD-1:0]                si_rgb;
  logic [CD-1:0]                so_rgb;
  logic [NUM_PLAYERS*3-1:0]     lives;
  logic                         game_over;
  logic                         winner_valid;
  logic [2:0]                   winner;

  modport master (
    output frame_tick, restart, x, y, pos_x, pos_y,
    output orientation, fire, colour, si_rgb,
    input  so_rgb, lives, game_over, winner_valid, winner
  );

  modport slave (
    input  frame_tick, restart, x, y, pos_x, pos_y,
    input  orientation, fire, colour, si_rgb,
    output so_rgb, lives, game_over, winner_valid, winner
  );
endinterface

// File: rtl/ghost_arena_multi.sv
// ghost_arena_multi: N-player bullets, hits, lives and
// hit-flash, composited over the incoming pixel stream.
module ghost_arena_multi #(
  parameter int NUM_PLAYERS = 2,
  parameter int CD = 12,
  parameter int COORD_W = 11,
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int SPRITE_SIZE = 32,
  parameter int BULLET_SIZE = 4,
  parameter int BULLET_SPEED = 4,
  parameter int MAX_LIVES = 3,
  parameter int FLASH_FRAMES = 16,
  parameter logic [CD-1:0] BULLET_COLOR = CD'(12'hFF0)
) (
  input logic clk,
  input logic reset,
  ghost_arena_multi_if.slave bus
);

  localparam int SW = COORD_W + 2;
  localparam int FLW = $clog2(FLASH_FRAMES + 1);
  localparam int FW = (FLW < 3) ? 3 : FLW;

  localparam logic signed [SW-1:0] SPD = SW'(BULLET_SPEED);
  localparam logic signed [SW-1:0] XMAX = SW'(H_RES - BULLET_SIZE);
  localparam logic signed [SW-1:0] YMAX = SW'(V_RES - BULLET_SIZE);
  localparam logic signed [SW-1:0] SPR = SW'(SPRITE_SIZE);
  localparam logic signed [SW-1:0] BSZ = SW'(BULLET_SIZE);
  localparam logic [COORD_W-1:0] OFS =
    COORD_W'(SPRITE_SIZE / 2 - BULLET_SIZE / 2);
  localparam logic [COORD_W:0] BSU = (COORD_W + 1)'(BULLET_SIZE);
  localparam logic [COORD_W:0] SPU = (COORD_W + 1)'(SPRITE_SIZE);
  localparam logic [2:0] LMAX = 3'(MAX_LIVES);
  localparam logic [FW-1:0] FLOAD = FW'(FLASH_FRAMES);

  typedef enum logic {IDLE, FLIGHT} bst_t;

  bst_t               st_q  [NUM_PLAYERS];
  bst_t               st_d  [NUM_PLAYERS];
  logic [COORD_W-1:0] bx_q  [NUM_PLAYERS];
  logic [COORD_W-1:0] bx_d  [NUM_PLAYERS];
  logic [COORD_W-1:0] by_q  [NUM_PLAYERS];
  logic [COORD_W-1:0] by_d  [NUM_PLAYERS];
  logic [1:0]         dir_q [NUM_PLAYERS];
  logic [1:0]         dir_d [NUM_PLAYERS];
  logic [2:0]         lv_q  [NUM_PLAYERS];
  logic [2:0]         lv_d  [NUM_PLAYERS];
  logic [FW-1:0]      fl_q  [NUM_PLAYERS];
  logic [FW-1:0]      fl_d  [NUM_PLAYERS];

  logic [COORD_W-1:0] pxa [NUM_PLAYERS];
  logic [COORD_W-1:0] pya [NUM_PLAYERS];
  logic [1:0]         ori [NUM_PLAYERS];
  logic [CD-1:0]      col [NUM_PLAYERS];
  logic signed [SW-1:0] nx [NUM_PLAYERS];
  logic signed [SW-1:0] ny [NUM_PLAYERS];

  logic [NUM_PLAYERS-1:0] pend_q, pend_d, fire_q, rise;
  logic [NUM_PLAYERS-1:0] off, hit, hurt;
  logic       go_q, go_d, wv_q, wv_d;
  logic [2:0] win_q, win_d;
  logic [3:0] cnt;
  logic [2:0] idx;
  logic [CD-1:0] pix_d, pix_q;

  function automatic logic signed [SW-1:0] sx(
    input logic [COORD_W-1:0] v);
    return signed'({2'b00, v});
  endfunction

  function automatic logic ovl(
    input logic signed [SW-1:0] b,
    input logic signed [SW-1:0] p);
    return (b < p + SPR) && (b + BSZ > p);
  endfunction

  function automatic logic inb(
    input logic [COORD_W-1:0] px, py, ox, oy,
    input logic [COORD_W:0] sz);
    return ({1'b0, px} >= {1'b0, ox}) &&
           ({1'b0, px} < {1'b0, ox} + sz) &&
           ({1'b0, py} >= {1'b0, oy}) &&
           ({1'b0, py} < {1'b0, oy} + sz);
  endfunction

  assign rise = bus.fire & ~fire_q;

  // Unpack the flat per-player buses.
  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      pxa[i] = bus.pos_x[i*COORD_W +: COORD_W];
      pya[i] = bus.pos_y[i*COORD_W +: COORD_W];
      ori[i] = bus.orientation[i*2 +: 2];
      col[i] = bus.colour[i*CD +: CD];
    end
  end

  // Candidate next bullet position and off-screen test.
  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      nx[i] = sx(bx_q[i]);
      ny[i] = sx(by_q[i]);
      unique case (dir_q[i])
        2'b00: nx[i] = sx(bx_q[i]) + SPD;
        2'b01: nx[i] = sx(bx_q[i]) - SPD;
        2'b10: ny[i] = sx(by_q[i]) - SPD;
        2'b11: ny[i] = sx(by_q[i]) + SPD;
      endcase
      off[i] = (nx[i] < 0) || (ny[i] < 0) ||
               (nx[i] > XMAX) || (ny[i] > YMAX);
    end
  end

  // Each live bullet picks its lowest-index live victim.
  always_comb begin
    logic found;
    found = 1'b0;
    hit = '0;
    hurt = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      found = 1'b0;
      if (st_q[i] == FLIGHT && !go_q) begin
        for (int j = 0; j < NUM_PLAYERS; j++) begin
          if (!found && j != i && lv_q[j] != 3'd0 &&
              ovl(nx[i], sx(pxa[j])) &&
              ovl(ny[i], sx(pya[j]))) begin
            found = 1'b1;
            hurt[j] = 1'b1;
          end
        end
      end
      hit[i] = found;
    end
  end

  // Next-state for bullets, lives, flash and game result.
  always_comb begin
    st_d = st_q;
    bx_d = bx_q;
    by_d = by_q;
    dir_d = dir_q;
    lv_d = lv_q;
    fl_d = fl_q;
    pend_d = pend_q;
    go_d = go_q;
    wv_d = wv_q;
    win_d = win_q;
    cnt = '0;
    idx = '0;
    if (bus.restart) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        st_d[i] = IDLE;
        lv_d[i] = LMAX;
        fl_d[i] = '0;
      end
      pend_d = '0;
      go_d = 1'b0;
      wv_d = 1'b0;
      win_d = '0;
    end else if (bus.frame_tick) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (st_q[i] == IDLE) begin
          if (pend_q[i] && lv_q[i] != 3'd0 && !go_q) begin
            st_d[i] = FLIGHT;
            bx_d[i] = pxa[i] + OFS;
            by_d[i] = pya[i] + OFS;
            dir_d[i] = ori[i];
          end
        end else if (off[i] || hit[i]) begin
          st_d[i] = IDLE;
        end else begin
          bx_d[i] = nx[i][COORD_W-1:0];
          by_d[i] = ny[i][COORD_W-1:0];
        end
        pend_d[i] = rise[i] && (st_d[i] == IDLE);
        if (hurt[i]) begin
          lv_d[i] = (lv_q[i] != 3'd0) ? lv_q[i] - 3'd1 : 3'd0;
          fl_d[i] = FLOAD;
        end else if (fl_q[i] != '0) begin
          fl_d[i] = fl_q[i] - 1'b1;
        end
      end
      for (int k = 0; k < NUM_PLAYERS; k++) begin
        if (lv_d[k] != 3'd0) begin
          cnt = cnt + 4'd1;
          idx = 3'(k);
        end
      end
      go_d = (cnt <= 4'd1);
      wv_d = (cnt == 4'd1);
      win_d = (cnt == 4'd1) ? idx : 3'd0;
    end else begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (rise[i] && st_q[i] == IDLE) pend_d[i] = 1'b1;
      end
    end
  end

  // Game state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        st_q[i] <= IDLE;
        bx_q[i] <= '0;
        by_q[i] <= '0;
        dir_q[i] <= '0;
        lv_q[i] <= LMAX;
        fl_q[i] <= '0;
      end
      pend_q <= '0;
      fire_q <= '0;
      go_q <= 1'b0;
      wv_q <= 1'b0;
      win_q <= '0;
    end else begin
      st_q <= st_d;
      bx_q <= bx_d;
      by_q <= by_d;
      dir_q <= dir_d;
      lv_q <= lv_d;
      fl_q <= fl_d;
      pend_q <= pend_d;
      fire_q <= bus.fire;
      go_q <= go_d;
      wv_q <= wv_d;
      win_q <= win_d;
    end
  end

  // Pixel mux: bullets over visible players over background.
  always_comb begin
    logic taken;
    taken = 1'b0;
    pix_d = bus.si_rgb;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (!taken && st_q[i] == FLIGHT &&
          inb(bus.x, bus.y, bx_q[i], by_q[i], BSU)) begin
        taken = 1'b1;
        pix_d = BULLET_COLOR;
      end
    end
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (!taken && lv_q[i] != 3'd0 &&
          !(fl_q[i] != '0 && !fl_q[i][2]) &&
          inb(bus.x, bus.y, pxa[i], pya[i], SPU)) begin
        taken = 1'b1;
        pix_d = col[i];
      end
    end
  end

  // Registered pixel output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pix_q <= '0;
    else pix_q <= pix_d;
  end

  // Flatten lives onto the bus.
  always_comb begin
    bus.lives = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      bus.lives[i*3 +: 3] = lv_q[i];
    end
  end

  assign bus.so_rgb = pix_q;
  assign bus.game_over = go_q;
  assign bus.winner_valid = wv_q;
  assign bus.winner = win_q;

endmodule
